// File: rtl/data_lane_hstx_if.sv
// PPI-side bundle for the data-lane HS transmitter: request/ready handshake,
// payload byte, serializer byte, and LP/HS line controls.
interface data_lane_hstx_if;
    logic       enable;
    logic       TxRequestHS;
    logic       DATA_LANE_START;
    logic [7:0] TxDataHS;
    logic       TxReadyHS;
    logic [7:0] HS_DATA;
    logic       HS_EN;
    logic       LP_DP;
    logic       LP_DN;
    logic       DATA_LANE_STP_S;

    modport master (
        output enable, TxRequestHS, DATA_LANE_START, TxDataHS,
        input  TxReadyHS, HS_DATA, HS_EN, LP_DP, LP_DN, DATA_LANE_STP_S
    );

    modport slave (
        input  enable, TxRequestHS, DATA_LANE_START, TxDataHS,
        output TxReadyHS, HS_DATA, HS_EN, LP_DP, LP_DN, DATA_LANE_STP_S
    );
endinterface

// File: rtl/data_lane_hstx.sv
// Data-lane HS transmit sequencer: LP-11 > LP-01 > LP-00 > HS-zero > sync > payload > trail > LP-11.
// Optional EoT packet before the trail when DATA_LANE_HSTX_EOTP_EN is defined.
module data_lane_hstx #(
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 2,
    parameter int unsigned T_HS_ZERO    = 4,
    parameter int unsigned T_HS_TRAIL   = 3,
    parameter int unsigned T_HS_EXIT    = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic             HS_BYTE_CLK,
    input  logic             TxRst,
    data_lane_hstx_if.slave  lane
);

`ifdef DATA_LANE_HSTX_EOTP_EN
    typedef enum logic [3:0] {
        S_STOP, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_EOTP, S_TRAIL, S_EXIT
    } state_t;
`else
    typedef enum logic [3:0] {
        S_STOP, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
    } state_t;
`endif

    localparam logic [7:0] C_LPX   = 8'(T_LPX - 1);
    localparam logic [7:0] C_PREP  = 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] C_ZERO  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] C_TRAIL = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] C_EXIT  = 8'(T_HS_EXIT - 1);

    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt;
    logic [7:0] r_hs_data, w_hs_data;
    logic       r_hs_en, w_hs_en;
    logic       r_lp_dp, w_lp_dp;
    logic       r_lp_dn, w_lp_dn;
    logic       r_stp, w_stp;
    logic       w_ready;
    logic       w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge HS_BYTE_CLK) begin
        if (TxRst) begin
            r_state <= S_STOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
        end
    end

    // Next state and counter; the counter is loaded with (param - 1) on entry.
    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt - 8'd1;
        w_ready = 1'b0;
        case (r_state)
            S_STOP: begin
                w_cnt = r_cnt;
                if (lane.TxRequestHS && lane.DATA_LANE_START) begin
                    w_next = S_LPX;
                    w_cnt  = C_LPX;
                end
            end
            S_LPX:  if (w_cnt_zero) begin w_next = S_PREP; w_cnt = C_PREP; end
            S_PREP: if (w_cnt_zero) begin w_next = S_ZERO; w_cnt = C_ZERO; end
            S_ZERO: if (w_cnt_zero) begin w_next = S_SYNC; w_cnt = '0;     end
            S_SYNC, S_DATA: begin
                w_cnt   = '0;
                w_ready = lane.TxRequestHS;
                if (lane.TxRequestHS) begin
                    w_next = S_DATA;
                end else begin
`ifdef DATA_LANE_HSTX_EOTP_EN
                    w_next = S_EOTP;
                    w_cnt  = 8'd3;
`else
                    w_next = S_TRAIL;
                    w_cnt  = C_TRAIL;
`endif
                end
            end
`ifdef DATA_LANE_HSTX_EOTP_EN
            S_EOTP:  if (w_cnt_zero) begin w_next = S_TRAIL; w_cnt = C_TRAIL; end
`endif
            S_TRAIL: if (w_cnt_zero) begin w_next = S_EXIT; w_cnt = C_EXIT; end
            S_EXIT:  if (w_cnt_zero) begin w_next = S_STOP; w_cnt = '0;     end
            default: begin w_next = S_STOP; w_cnt = '0; end
        endcase
        if (!lane.enable) begin
            w_next = S_STOP;
            w_cnt  = '0;
        end
    end

    // Line outputs are registered from the state being entered.
    always_comb begin
        w_hs_data = '0;
        w_hs_en   = 1'b0;
        w_lp_dp   = 1'b0;
        w_lp_dn   = 1'b0;
        w_stp     = 1'b0;
        case (w_next)
            S_STOP: begin w_lp_dp = 1'b1; w_lp_dn = 1'b1; w_stp = 1'b1; end
            S_LPX:  w_lp_dn = 1'b1;
            S_PREP: ;
            S_ZERO: w_hs_en = 1'b1;
            S_SYNC: begin w_hs_en = 1'b1; w_hs_data = SYNC_BYTE; end
            S_DATA: begin w_hs_en = 1'b1; w_hs_data = lane.TxDataHS; end
`ifdef DATA_LANE_HSTX_EOTP_EN
            S_EOTP: begin
                w_hs_en = 1'b1;
                if (r_state != S_EOTP) w_hs_data = 8'h08;
                else if (r_cnt == 8'd1) w_hs_data = 8'h01;
                else w_hs_data = 8'h0F;
            end
`endif
            // Trail repeats the complement of the last bit on the wire, i.e. bit 7 of the prior byte.
            S_TRAIL: begin
                w_hs_en   = 1'b1;
                w_hs_data = (r_state == S_TRAIL) ? r_hs_data : {8{~r_hs_data[7]}};
            end
            S_EXIT: begin w_lp_dp = 1'b1; w_lp_dn = 1'b1; end
            default: begin w_lp_dp = 1'b1; w_lp_dn = 1'b1; w_stp = 1'b1; end
        endcase
    end

    always_ff @(posedge HS_BYTE_CLK) begin
        if (TxRst) begin
            r_hs_data <= '0;
            r_hs_en   <= 1'b0;
            r_lp_dp   <= 1'b1;
            r_lp_dn   <= 1'b1;
            r_stp     <= 1'b1;
        end else begin
            r_hs_data <= w_hs_data;
            r_hs_en   <= w_hs_en;
            r_lp_dp   <= w_lp_dp;
            r_lp_dn   <= w_lp_dn;
            r_stp     <= w_stp;
        end
    end

    assign lane.TxReadyHS       = w_ready;
    assign lane.HS_DATA         = r_hs_data;
    assign lane.HS_EN           = r_hs_en;
    assign lane.LP_DP           = r_lp_dp;
    assign lane.LP_DN           = r_lp_dn;
    assign lane.DATA_LANE_STP_S = r_stp;

endmodule

// File: tb/tb_data_lane_hstx.sv
// Bench for data_lane_hstx: directed and randomized bursts checked against a
// per-cycle expected line timeline built from the sequence rules.
module tb_data_lane_hstx;
    localparam int TL = 2, TP = 2, TZ = 4, TT = 3, TE = 2;
    localparam logic [7:0] SB = 8'hB8;
    localparam int PRE = TL + TP + TZ + 1;

    typedef struct packed {
        logic       en;
        logic       dp;
        logic       dn;
        logic       stp;
        logic [7:0] d;
        logic       win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    logic [7:0] pay[8];

    data_lane_hstx_if bus ();

    data_lane_hstx #(
        .T_LPX(TL), .T_HS_PREPARE(TP), .T_HS_ZERO(TZ),
        .T_HS_TRAIL(TT), .T_HS_EXIT(TE), .SYNC_BYTE(SB)
    ) dut (
        .HS_BYTE_CLK(clk),
        .TxRst(rst),
        .lane(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_stop(input string tag);
        chk({tag, ".hs_data"}, bus.HS_DATA, 8'h00);
        chk({tag, ".hs_en"}, bus.HS_EN, 8'd0);
        chk({tag, ".lp_dp"}, bus.LP_DP, 8'd1);
        chk({tag, ".lp_dn"}, bus.LP_DN, 8'd1);
        chk({tag, ".stp"}, bus.DATA_LANE_STP_S, 8'd1);
        chk({tag, ".ready"}, bus.TxReadyHS, 8'd0);
    endtask

    // Expected line state sampled in each cycle after the start edge.
    task automatic build(input int n);
        logic [7:0] last;
        logic [7:0] eot[4];
        eot = '{8'h08, 8'h0F, 8'h0F, 8'h01};
        q.delete();
        for (int i = 0; i < TL; i++) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < TP; i++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < TZ; i++) q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, SB, 1'b1});
        last = SB;
        for (int i = 0; i < n; i++) begin
            q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, pay[i], 1'b1});
            last = pay[i];
        end
`ifdef DATA_LANE_HSTX_EOTP_EN
        for (int i = 0; i < 4; i++) begin
            q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, eot[i], 1'b0});
            last = eot[i];
        end
`endif
        for (int i = 0; i < TT; i++) q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, {8{~last[7]}}, 1'b0});
        for (int i = 0; i < TE; i++) q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
        q.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0});
    endtask

    // abort_k < 0 runs the burst to completion; otherwise abort after that cycle's check.
    task automatic burst(input int n, input int abort_k, input bit use_rst);
        int   idx = 0;
        int   pulses = 0;
        logic req;
        exp_t e;
        build(n);
        @(negedge clk);
        bus.enable = 1'b1;
        bus.DATA_LANE_START = 1'b1;
        bus.TxRequestHS = 1'b1;
        bus.TxDataHS = 8'($urandom);
        @(posedge clk);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            e = q[k];
            chk($sformatf("c%0d.hs_data", k + 1), bus.HS_DATA, e.d);
            chk($sformatf("c%0d.hs_en", k + 1), bus.HS_EN, e.en);
            chk($sformatf("c%0d.lp_dp", k + 1), bus.LP_DP, e.dp);
            chk($sformatf("c%0d.lp_dn", k + 1), bus.LP_DN, e.dn);
            chk($sformatf("c%0d.stp", k + 1), bus.DATA_LANE_STP_S, e.stp);
            if (k == abort_k) begin
                if (use_rst) rst = 1'b1;
                else bus.enable = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_stop(use_rst ? "rst_abort" : "en_abort");
                rst = 1'b0;
                bus.enable = 1'b1;
                bus.TxRequestHS = 1'b0;
                bus.DATA_LANE_START = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_stop("post_abort");
                end
                return;
            end
            req = (k + 1 < PRE) || (idx < n);
            bus.TxRequestHS = req;
            bus.TxDataHS = (idx < n) ? pay[idx] : 8'($urandom);
            #1;
            chk($sformatf("c%0d.ready", k + 1), bus.TxReadyHS, e.win && req);
            if (bus.TxReadyHS === 1'b1) pulses++;
            if (e.win && req) idx++;
        end
        chk("ready_pulses", 8'(pulses), 8'(n));
        bus.DATA_LANE_START = 1'b0;
    endtask

    initial begin
        int n;
        bus.enable = 1'b0;
        bus.TxRequestHS = 1'b0;
        bus.DATA_LANE_START = 1'b0;
        bus.TxDataHS = 8'h00;

        // Reset with arbitrary inputs.
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.enable = 1'($urandom);
            bus.TxRequestHS = 1'($urandom);
            bus.DATA_LANE_START = 1'($urandom);
            bus.TxDataHS = 8'($urandom);
        end
        @(negedge clk);
        check_stop("reset");
        bus.enable = 1'b1;
        bus.TxRequestHS = 1'b0;
        bus.DATA_LANE_START = 1'b0;
        rst = 1'b0;

        // Request without clock-lane permission waits in STOP.
        bus.TxRequestHS = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_stop("gated");
        end

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h83;
        burst(3, -1, 1'b0);
        pay[0] = 8'h7F;
        burst(1, -1, 1'b0);
        burst(0, -1, 1'b0);
        pay[0] = 8'h83;
        burst(1, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
            burst(n, -1, 1'b0);
        end

        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        burst(5, PRE + 2, 1'b0);
        burst(5, TL + TP + 1, 1'b1);
        pay[0] = 8'h01; pay[1] = 8'h80;
        burst(2, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
